// File: rtl/decryption_arbiter.sv
// decryption_arbiter
// Shares one caesar decryption engine between two byte-stream requesters.
// A requester keeps the engine for a whole frame, which its `last` flag closes.
// Arbitration between frames is round-robin. The frame key is latched once,
// at grant time. Each decrypted byte is tagged with the ID of its source.
// A requester that stalls mid-frame for TIMEOUT idle cycles loses the grant,
// and `abort` pulses for one cycle.
//
// Ports
//   clk, rst_n          clock; synchronous reset, active HIGH (rst_n=1 resets)
//   reqK_data/key       requester K ciphertext byte and key (key sampled at grant)
//   reqK_valid/last     requester K byte valid / last byte of frame
//   reqK_ready          requester K byte accepted (combinational)
//   eng_data_i/key      byte and latched frame key to the engine
//   eng_valid_i         engine input strobe (combinational, equals the transfer)
//   eng_busy            engine stall
//   eng_data_o/valid_o  engine plaintext and strobe
//   out_data/valid/id   registered plaintext, valid and source requester
//   abort, abort_id     one-cycle pulse when a grant is revoked by timeout
module decryption_arbiter #(
  parameter int D_WIDTH     = 8,
  parameter int KEY_WIDTH   = 16,
  parameter int ENG_LATENCY = 1,
  parameter int TIMEOUT     = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [D_WIDTH-1:0]   req0_data,
  input  logic [KEY_WIDTH-1:0] req0_key,
  input  logic                 req0_valid,
  input  logic                 req0_last,
  output logic                 req0_ready,
  input  logic [D_WIDTH-1:0]   req1_data,
  input  logic [KEY_WIDTH-1:0] req1_key,
  input  logic                 req1_valid,
  input  logic                 req1_last,
  output logic                 req1_ready,
  output logic [D_WIDTH-1:0]   eng_data_i,
  output logic [KEY_WIDTH-1:0] eng_key,
  output logic                 eng_valid_i,
  input  logic                 eng_busy,
  input  logic [D_WIDTH-1:0]   eng_data_o,
  input  logic                 eng_valid_o,
  output logic [D_WIDTH-1:0]   out_data,
  output logic                 out_valid,
  output logic                 out_id,
  output logic                 abort,
  output logic                 abort_id
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, GRANT0, GRANT1} state_t;

  state_t               state_reg, state_next;
  logic                 rr_last_reg, rr_last_next;
  logic [KEY_WIDTH-1:0] key_reg, key_next;
  logic [CNT_W-1:0]     idle_cnt_reg, idle_cnt_next;
  logic                 abort_reg, abort_next;
  logic                 abort_id_reg, abort_id_next;
  logic                 tag_in;
  logic                 tag_reg [ENG_LATENCY];
  logic [D_WIDTH-1:0]   out_data_reg;
  logic                 out_valid_reg;
  logic                 out_id_reg;

  // Signals of whichever requester currently owns the engine.
  logic               gid;
  logic               sel_valid;
  logic               sel_last;
  logic [D_WIDTH-1:0] sel_data;
  logic               xfer;

  assign gid       = (state_reg == GRANT1);
  assign sel_valid = gid ? req1_valid : req0_valid;
  assign sel_last  = gid ? req1_last  : req0_last;
  assign sel_data  = gid ? req1_data  : req0_data;
  assign xfer      = (state_reg != IDLE) && sel_valid && !eng_busy;
  assign tag_in    = gid;

  always_comb begin
    state_next    = state_reg;
    rr_last_next  = rr_last_reg;
    key_next      = key_reg;
    idle_cnt_next = idle_cnt_reg;
    abort_next    = 1'b0;
    abort_id_next = abort_id_reg;
    req0_ready    = 1'b0;
    req1_ready    = 1'b0;
    eng_valid_i   = 1'b0;
    eng_data_i    = '0;

    case (state_reg)
      IDLE: begin
        // When both requesters are valid, the one that was not served last wins.
        if (req0_valid && (!req1_valid || rr_last_reg)) begin
          state_next    = GRANT0;
          key_next      = req0_key;
          idle_cnt_next = '0;
        end else if (req1_valid) begin
          state_next    = GRANT1;
          key_next      = req1_key;
          idle_cnt_next = '0;
        end
      end
      GRANT0, GRANT1: begin
        req0_ready  = !gid && !eng_busy;
        req1_ready  = gid && !eng_busy;
        eng_valid_i = xfer;
        eng_data_i  = sel_data;
        if (xfer) begin
          idle_cnt_next = '0;
          if (sel_last) begin
            state_next   = IDLE;
            rr_last_next = gid;
          end
        end else if (!sel_valid && !eng_busy) begin
          // Engine stalls are not idleness; only an absent requester counts.
          if (idle_cnt_reg == CNT_W'(TIMEOUT - 1)) begin
            state_next    = IDLE;
            rr_last_next  = gid;
            idle_cnt_next = '0;
            abort_next    = 1'b1;
            abort_id_next = gid;
          end else begin
            idle_cnt_next = idle_cnt_reg + 1'b1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_reg     <= IDLE;
      rr_last_reg   <= 1'b1;
      key_reg       <= '0;
      idle_cnt_reg  <= '0;
      abort_reg     <= 1'b0;
      abort_id_reg  <= 1'b0;
      out_data_reg  <= '0;
      out_valid_reg <= 1'b0;
      out_id_reg    <= 1'b0;
    end else begin
      state_reg     <= state_next;
      rr_last_reg   <= rr_last_next;
      key_reg       <= key_next;
      idle_cnt_reg  <= idle_cnt_next;
      abort_reg     <= abort_next;
      abort_id_reg  <= abort_id_next;
      out_valid_reg <= eng_valid_o;
      out_data_reg  <= eng_valid_o ? eng_data_o : '0;
      out_id_reg    <= eng_valid_o & tag_reg[ENG_LATENCY-1];
    end
  end

  // The tag pipeline runs alongside the engine, so each tag lines up with its plaintext.
  for (genvar gi = 0; gi < ENG_LATENCY; gi++) begin : g_tag
    if (gi == 0) begin : g_head
      always_ff @(posedge clk) begin
        if (rst_n) tag_reg[gi] <= 1'b0;
        else       tag_reg[gi] <= tag_in;
      end
    end else begin : g_body
      always_ff @(posedge clk) begin
        if (rst_n) tag_reg[gi] <= 1'b0;
        else       tag_reg[gi] <= tag_reg[gi-1];
      end
    end
  end

  assign eng_key   = key_reg;
  assign abort     = abort_reg;
  assign abort_id  = abort_id_reg;
  assign out_data  = out_data_reg;
  assign out_valid = out_valid_reg;
  assign out_id    = out_id_reg;

endmodule
